// File: rtl/calc2_req_issuer_if.sv
// Operation, CALC2 request/response and report signals of one CALC2 request port.
// slave = the issuer's view, master = the requester/CALC2 environment's view.
interface calc2_req_issuer_if #(
  parameter int DATA_W = 32
);
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_cmd;
  logic [DATA_W-1:0] op_d1;
  logic [DATA_W-1:0] op_d2;
  logic [3:0]        req_cmd_out;
  logic [1:0]        req_tag_out;
  logic [DATA_W-1:0] req_data_out;
  logic [1:0]        out_resp;
  logic [1:0]        out_tag;
  logic [DATA_W-1:0] out_data;
  logic              rsp_valid;
  logic [1:0]        rsp_tag;
  logic [1:0]        rsp_resp;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_timeout;
  logic              rsp_spurious;
  logic [3:0]        busy_tags;

  modport slave (
    input  op_valid, op_cmd, op_d1, op_d2, out_resp, out_tag, out_data,
    output op_ready, req_cmd_out, req_tag_out, req_data_out,
           rsp_valid, rsp_tag, rsp_resp, rsp_data, rsp_timeout, rsp_spurious, busy_tags
  );

  modport master (
    output op_valid, op_cmd, op_d1, op_d2, out_resp, out_tag, out_data,
    input  op_ready, req_cmd_out, req_tag_out, req_data_out,
           rsp_valid, rsp_tag, rsp_resp, rsp_data, rsp_timeout, rsp_spurious, busy_tags
  );
endinterface

// File: rtl/calc2_req_issuer.sv
// Serialises tagged operations onto the CALC2 two-cycle request protocol and
// reports matching responses or per-tag timeouts, one report per cycle.
module calc2_req_issuer #(
  parameter int TIMEOUT = 64,
  parameter int DATA_W  = 32
) (
  input logic            c_clk,
  input logic            reset,
  calc2_req_issuer_if.slave bus
);

  localparam int            CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP1  = 2'd1;
  localparam logic [1:0] OP2  = 2'd2;

  logic [1:0]        state;
  logic [3:0]        busy;
  logic [CW-1:0]     cnt [4];
  logic [DATA_W-1:0] d2_p0;

  logic       ready;
  logic       accept;
  logic       cap;
  logic       spur;
  logic       tmo_hit;
  logic [1:0] alloc_tag;
  logic [1:0] tmo_tag;
  logic [3:0] expired;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= TMO) ? TMO : v + 1'b1;
  endfunction

  always_comb begin
    ready     = ((state == IDLE) || (state == OP2)) && (busy != 4'hf);
    accept    = bus.op_valid && ready;
    alloc_tag = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!busy[i]) alloc_tag = 2'(i);
    end
    cap  = (bus.out_resp != 2'd0) && busy[bus.out_tag];
    spur = (bus.out_resp != 2'd0) && !busy[bus.out_tag];
    // A real response always wins the report slot; expired tags wait saturated.
    tmo_tag = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      expired[i] = busy[i] && (cnt[i] == TMO);
      if (expired[i]) tmo_tag = 2'(i);
    end
    tmo_hit = !cap && (expired != 4'd0);
  end

  assign bus.op_ready  = ready;
  assign bus.busy_tags = busy;

  // Issue stage: OP1 carries cmd/tag/d1, OP2 carries d2 held from the accept.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bus.req_cmd_out  <= 4'd0;
      bus.req_tag_out  <= 2'd0;
      bus.req_data_out <= '0;
      d2_p0            <= '0;
    end else if (accept) begin
      state            <= OP1;
      bus.req_cmd_out  <= bus.op_cmd;
      bus.req_tag_out  <= alloc_tag;
      bus.req_data_out <= bus.op_d1;
      d2_p0            <= bus.op_d2;
    end else if (state == OP1) begin
      state            <= OP2;
      bus.req_cmd_out  <= 4'd0;
      bus.req_tag_out  <= 2'd0;
      bus.req_data_out <= d2_p0;
    end else begin
      state            <= IDLE;
      bus.req_cmd_out  <= 4'd0;
      bus.req_tag_out  <= 2'd0;
      bus.req_data_out <= '0;
    end
  end

  // Tag tracking: the allocated tag is always clear, so it never collides with a freed one.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      busy <= 4'd0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (alloc_tag == 2'(i))) begin
          busy[i] <= 1'b1;
          cnt[i]  <= CW'(1);
        end else if ((cap && (bus.out_tag == 2'(i))) || (tmo_hit && (tmo_tag == 2'(i)))) begin
          busy[i] <= 1'b0;
          cnt[i]  <= '0;
        end else if (busy[i]) begin
          cnt[i]  <= sat_inc(cnt[i]);
        end
      end
    end
  end

  // Report stage: tag/resp/data hold between reports; valid/timeout/spurious pulse.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid    <= 1'b0;
      bus.rsp_tag      <= 2'd0;
      bus.rsp_resp     <= 2'd0;
      bus.rsp_data     <= '0;
      bus.rsp_timeout  <= 1'b0;
      bus.rsp_spurious <= 1'b0;
    end else begin
      bus.rsp_spurious <= spur;
      if (cap) begin
        bus.rsp_valid   <= 1'b1;
        bus.rsp_tag     <= bus.out_tag;
        bus.rsp_resp    <= bus.out_resp;
        bus.rsp_data    <= bus.out_data;
        bus.rsp_timeout <= 1'b0;
      end else if (tmo_hit) begin
        bus.rsp_valid   <= 1'b1;
        bus.rsp_tag     <= tmo_tag;
        bus.rsp_resp    <= 2'd0;
        bus.rsp_data    <= '0;
        bus.rsp_timeout <= 1'b1;
      end else begin
        bus.rsp_valid   <= 1'b0;
        bus.rsp_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc2_req_issuer.sv
// Bench for calc2_req_issuer: directed scenarios plus a randomized run against
// a tag/issue-time reference model.
module tb_calc2_req_issuer;
  localparam int TIMEOUT = 64;

  logic c_clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  calc2_req_issuer_if bus();

  calc2_req_issuer #(.TIMEOUT(TIMEOUT)) dut (
    .c_clk(c_clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 c_clk = ~c_clk;

  // Reference model: which tags are busy, when each tag's OP1 cycle was,
  // which operation is on the request bus, and the last report.
  bit          m_busy [4];
  int          m_op1 [4];
  int          m_phase;
  logic [3:0]  m_cmd;
  logic [1:0]  m_tag;
  logic [31:0] m_d1, m_d2;
  bit          m_valid, m_tmo, m_spur;
  logic [1:0]  m_rtag, m_rresp;
  logic [31:0] m_rdata;
  int          m_cyc;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_busy[i] = 0; m_op1[i] = 0; end
    m_phase = 0; m_cmd = 0; m_tag = 0; m_d1 = 0; m_d2 = 0;
    m_valid = 0; m_tmo = 0; m_spur = 0; m_rtag = 0; m_rresp = 0; m_rdata = 0;
    m_cyc = 0;
  endtask

  function automatic bit model_ready();
    return (m_phase != 1) && !(m_busy[0] && m_busy[1] && m_busy[2] && m_busy[3]);
  endfunction

  task automatic model_edge();
    bit rdy = model_ready();
    int alloc = -1;
    int freed = -1;
    for (int i = 0; i < 4; i++) if (!m_busy[i] && alloc < 0) alloc = i;
    m_valid = 0; m_tmo = 0; m_spur = 0;
    if (bus.out_resp != 0 && m_busy[bus.out_tag]) begin
      m_valid = 1; m_rtag = bus.out_tag; m_rresp = bus.out_resp; m_rdata = bus.out_data;
      freed = bus.out_tag;
    end else begin
      if (bus.out_resp != 0) m_spur = 1;
      for (int i = 0; i < 4; i++) begin
        if (freed < 0 && m_busy[i] && (m_cyc - m_op1[i] + 1 >= TIMEOUT)) begin
          m_valid = 1; m_tmo = 1; m_rtag = 2'(i); m_rresp = 0; m_rdata = 0;
          freed = i;
        end
      end
    end
    if (freed >= 0) m_busy[freed] = 0;
    if (bus.op_valid && rdy) begin
      m_busy[alloc] = 1; m_op1[alloc] = m_cyc + 1;
      m_phase = 1; m_cmd = bus.op_cmd; m_tag = 2'(alloc); m_d1 = bus.op_d1; m_d2 = bus.op_d2;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
    m_cyc++;
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.op_valid = 0; bus.op_cmd = 0; bus.op_d1 = 0; bus.op_d2 = 0;
    bus.out_resp = 0; bus.out_tag = 0; bus.out_data = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.req_cmd_out, bus.req_tag_out, bus.req_data_out} !== 38'd0) begin
      failures++; $display("FAIL reset_req got=%0h want=0", {bus.req_cmd_out, bus.req_tag_out, bus.req_data_out});
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_resp, bus.rsp_data, bus.rsp_timeout, bus.rsp_spurious} !== 39'd0) begin
      failures++; $display("FAIL reset_rsp got=%0h want=0", {bus.rsp_valid, bus.rsp_tag, bus.rsp_resp, bus.rsp_data, bus.rsp_timeout, bus.rsp_spurious});
    end
    checks++;
    if (bus.busy_tags !== 4'b0000 || bus.op_ready !== 1'b1) begin
      failures++; $display("FAIL reset_busy_ready got busy=%b ready=%b want busy=0000 ready=1", bus.busy_tags, bus.op_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    bus.op_valid = 1; bus.op_cmd = 4'd1; bus.op_d1 = 32'h5; bus.op_d2 = 32'h3;
    tick();
    bus.op_valid = 0;
    checks++;
    if ({bus.req_cmd_out, bus.req_tag_out, bus.req_data_out} !== {4'd1, 2'd0, 32'h5}) begin
      failures++; $display("FAIL basic_op1 got=%0h want=%0h", {bus.req_cmd_out, bus.req_tag_out, bus.req_data_out}, {4'd1, 2'd0, 32'h5});
    end
    tick();
    checks++;
    if ({bus.req_cmd_out, bus.req_tag_out, bus.req_data_out} !== {4'd0, 2'd0, 32'h3} || bus.busy_tags !== 4'b0001) begin
      failures++; $display("FAIL basic_op2 got=%0h busy=%b want=%0h busy=0001", {bus.req_cmd_out, bus.req_tag_out, bus.req_data_out}, bus.busy_tags, {4'd0, 2'd0, 32'h3});
    end
    bus.out_resp = 2'd1; bus.out_tag = 2'd0; bus.out_data = 32'h8;
    tick();
    idle_inputs();
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag, bus.rsp_resp, bus.rsp_data} !== {1'b1, 1'b0, 2'd0, 2'd1, 32'h8} || bus.busy_tags !== 4'b0000) begin
      failures++; $display("FAIL basic_rsp got valid=%b tmo=%b tag=%0d resp=%0d data=%0h busy=%b want 1 0 0 1 8 0000",
                           bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag, bus.rsp_resp, bus.rsp_data, bus.busy_tags);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h8 || bus.rsp_tag !== 2'd0 || bus.rsp_resp !== 2'd1) begin
      failures++; $display("FAIL basic_hold got valid=%b data=%0h want valid=0 data=8", bus.rsp_valid, bus.rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.op_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.op_cmd = 4'(i + 1); bus.op_d1 = 32'(i * 16 + 1); bus.op_d2 = 32'(i);
      checks++;
      if (bus.op_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_ready_%0d got=%b want=1", i, bus.op_ready);
      end
      tick();
      checks++;
      if ({bus.req_cmd_out, bus.req_tag_out} !== {4'(i + 1), 2'(i)} || bus.op_ready !== 1'b0) begin
        failures++; $display("FAIL b2b_op1_%0d got cmd=%0d tag=%0d ready=%b want cmd=%0d tag=%0d ready=0",
                             i, bus.req_cmd_out, bus.req_tag_out, bus.op_ready, i + 1, i);
      end
      tick();
    end
    bus.op_valid = 0;
    checks++;
    if (bus.op_ready !== 1'b0 || bus.busy_tags !== 4'b1111) begin
      failures++; $display("FAIL b2b_full got ready=%b busy=%b want ready=0 busy=1111", bus.op_ready, bus.busy_tags);
    end
    bus.out_resp = 2'd2; bus.out_tag = 2'd2; bus.out_data = 32'hABC;
    tick();
    idle_inputs();
    checks++;
    if (bus.op_ready !== 1'b1 || bus.busy_tags !== 4'b1011 || bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 2'd2) begin
      failures++; $display("FAIL b2b_free got ready=%b busy=%b valid=%b tag=%0d want 1 1011 1 2",
                           bus.op_ready, bus.busy_tags, bus.rsp_valid, bus.rsp_tag);
    end
    bus.op_valid = 1; bus.op_cmd = 4'd6; bus.op_d1 = 32'h77; bus.op_d2 = 32'h2;
    tick();
    bus.op_valid = 0;
    checks++;
    if ({bus.req_cmd_out, bus.req_tag_out, bus.req_data_out} !== {4'd6, 2'd2, 32'h77} || bus.busy_tags !== 4'b1111) begin
      failures++; $display("FAIL b2b_reuse got cmd=%0d tag=%0d data=%0h busy=%b want 6 2 77 1111",
                           bus.req_cmd_out, bus.req_tag_out, bus.req_data_out, bus.busy_tags);
    end
  endtask

  task automatic test_timeout();
    int seen = 0;
    do_reset();
    bus.op_valid = 1; bus.op_cmd = 4'd2; bus.op_d1 = 32'h10; bus.op_d2 = 32'h1;
    tick();
    bus.op_valid = 0;
    for (int n = 1; n <= TIMEOUT + 8 && seen == 0; n++) begin
      tick();
      if (bus.rsp_valid === 1'b1) seen = n;
    end
    checks++;
    if (seen != TIMEOUT) begin
      failures++; $display("FAIL timeout_latency got=%0d want=%0d", seen, TIMEOUT);
    end
    checks++;
    if ({bus.rsp_timeout, bus.rsp_tag, bus.rsp_resp, bus.rsp_data} !== {1'b1, 2'd0, 2'd0, 32'd0} || bus.busy_tags !== 4'b0000) begin
      failures++; $display("FAIL timeout_report got tmo=%b tag=%0d resp=%0d data=%0h busy=%b want 1 0 0 0 0000",
                           bus.rsp_timeout, bus.rsp_tag, bus.rsp_resp, bus.rsp_data, bus.busy_tags);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_timeout !== 1'b0) begin
      failures++; $display("FAIL timeout_pulse got valid=%b tmo=%b want 0 0", bus.rsp_valid, bus.rsp_timeout);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    bus.out_resp = 2'd1; bus.out_tag = 2'd3; bus.out_data = 32'hDEAD;
    tick();
    idle_inputs();
    checks++;
    if (bus.rsp_spurious !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy_tags !== 4'b0000 || bus.rsp_data !== 32'd0) begin
      failures++; $display("FAIL spurious got spur=%b valid=%b busy=%b data=%0h want 1 0 0000 0",
                           bus.rsp_spurious, bus.rsp_valid, bus.busy_tags, bus.rsp_data);
    end
    tick();
    checks++;
    if (bus.rsp_spurious !== 1'b0) begin
      failures++; $display("FAIL spurious_pulse got=%b want=0", bus.rsp_spurious);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    bus.op_valid = 1; bus.op_cmd = 4'd1; bus.op_d1 = 32'h1; bus.op_d2 = 32'h2;
    tick();
    bus.op_valid = 0;
    tick();
    bus.op_valid = 1; bus.op_cmd = 4'd5;
    tick();
    bus.op_valid = 0;
    repeat (TIMEOUT - 3) tick();
    bus.out_resp = 2'd1; bus.out_tag = 2'd1; bus.out_data = 32'h77;
    tick();
    idle_inputs();
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag, bus.rsp_data} !== {1'b1, 1'b0, 2'd1, 32'h77} || bus.busy_tags !== 4'b0001) begin
      failures++; $display("FAIL arb_first got valid=%b tmo=%b tag=%0d data=%0h busy=%b want 1 0 1 77 0001",
                           bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag, bus.rsp_data, bus.busy_tags);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag, bus.rsp_data} !== {1'b1, 1'b1, 2'd0, 32'h0} || bus.busy_tags !== 4'b0000) begin
      failures++; $display("FAIL arb_second got valid=%b tmo=%b tag=%0d data=%0h busy=%b want 1 1 0 0 0000",
                           bus.rsp_valid, bus.rsp_timeout, bus.rsp_tag, bus.rsp_data, bus.busy_tags);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.op_valid = 1; bus.op_cmd = 4'd6; bus.op_d1 = 32'h11; bus.op_d2 = 32'h22;
    tick();
    bus.op_valid = 0;
    tick();
    checks++;
    if (bus.req_data_out !== 32'h22) begin
      failures++; $display("FAIL rmid_op2 got=%0h want=22", bus.req_data_out);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.req_cmd_out, bus.req_tag_out, bus.req_data_out} !== 38'd0 || bus.busy_tags !== 4'b0000) begin
      failures++; $display("FAIL rmid_async got req=%0h busy=%b want 0 0000", {bus.req_cmd_out, bus.req_tag_out, bus.req_data_out}, bus.busy_tags);
    end
    tick();
    reset = 1'b0;
    model_reset();
    checks++;
    if (bus.op_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_ready got=%b want=1", bus.op_ready);
    end
    bus.op_valid = 1; bus.op_cmd = 4'd1; bus.op_d1 = 32'h99;
    tick();
    bus.op_valid = 0;
    checks++;
    if ({bus.req_cmd_out, bus.req_tag_out, bus.req_data_out} !== {4'd1, 2'd0, 32'h99}) begin
      failures++; $display("FAIL rmid_tag got cmd=%0d tag=%0d data=%0h want 1 0 99", bus.req_cmd_out, bus.req_tag_out, bus.req_data_out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int rate = (c < 1500) ? 6 : 40;
      bus.op_valid = ($urandom_range(0, 1) == 1);
      bus.op_cmd   = 4'($urandom);
      bus.op_d1    = $urandom;
      bus.op_d2    = $urandom;
      if ($urandom_range(0, rate - 1) == 0) begin
        bus.out_resp = 2'($urandom_range(1, 3));
        bus.out_tag  = 2'($urandom);
        bus.out_data = $urandom;
      end else begin
        bus.out_resp = 0; bus.out_tag = 2'($urandom); bus.out_data = $urandom;
      end
      checks++;
      if (bus.op_ready !== model_ready()) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, bus.op_ready, model_ready());
      end
      model_edge();
      tick();
      checks++;
      if ({bus.req_cmd_out, bus.req_tag_out, bus.req_data_out} !==
          {(m_phase == 1) ? m_cmd : 4'd0, (m_phase == 1) ? m_tag : 2'd0,
           (m_phase == 1) ? m_d1 : (m_phase == 2) ? m_d2 : 32'd0}) begin
        failures++; $display("FAIL rand_req cyc=%0d got cmd=%0d tag=%0d data=%0h phase=%0d want cmd=%0d tag=%0d d1=%0h d2=%0h",
                             c, bus.req_cmd_out, bus.req_tag_out, bus.req_data_out, m_phase, m_cmd, m_tag, m_d1, m_d2);
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_spurious, bus.rsp_tag, bus.rsp_resp, bus.rsp_data} !==
          {m_valid, m_tmo, m_spur, m_rtag, m_rresp, m_rdata}) begin
        failures++; $display("FAIL rand_rsp cyc=%0d got v=%b t=%b s=%b tag=%0d resp=%0d data=%0h want v=%b t=%b s=%b tag=%0d resp=%0d data=%0h",
                             c, bus.rsp_valid, bus.rsp_timeout, bus.rsp_spurious, bus.rsp_tag, bus.rsp_resp, bus.rsp_data,
                             m_valid, m_tmo, m_spur, m_rtag, m_rresp, m_rdata);
      end
      checks++;
      if (bus.busy_tags !== {m_busy[3], m_busy[2], m_busy[1], m_busy[0]}) begin
        failures++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", c, bus.busy_tags, {m_busy[3], m_busy[2], m_busy[1], m_busy[0]});
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_spurious();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/calc2_req_issuer.md
Name: calc2_req_issuer

Overview:
Upstream driver for one CALC2 request port. It accepts abstract operations (cmd, operand1, operand2) over a valid/ready handshake and allocates a free 2-bit tag. It serialises each operation onto the CALC2 two-cycle request protocol, tracks up to 4 outstanding tags, and returns each matching CALC2 response (or a timeout) to the requester. One instance sits in front of each of the four CALC2 ports.

Parameters:
TIMEOUT, 64, cycles from the operand-1 cycle to the forced-timeout report; legal range 2..1023.

Ports:
c_clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high reset
op_valid  in  1  operation offered
op_ready  out  1  operation accepted when op_valid&&op_ready at posedge
op_cmd  in  4  CALC2 command (1 add, 2 sub, 5 shl, 6 shr; others passed through)
op_d1  in  32  operand 1
op_d2  in  32  operand 2
req_cmd_out  out  4  to CALC2 reqN_cmd_in
req_tag_out  out  2  to CALC2 reqN_tag_in
req_data_out  out  32  to CALC2 reqN_data_in
out_resp  in  2  from CALC2 out_respN (0 = no response)
out_tag  in  2  from CALC2 out_tagN
out_data  in  32  from CALC2 out_dataN
rsp_valid  out  1  one-cycle pulse, result or timeout reported
rsp_tag  out  2  tag of reported operation
rsp_resp  out  2  CALC2 response code; 0 on timeout
rsp_data  out  32  CALC2 result; 0 on timeout
rsp_timeout  out  1  qualifies rsp_valid as a timeout
rsp_spurious  out  1  one-cycle pulse, response on a non-busy tag
busy_tags  out  4  bit i = tag i outstanding

Behaviour:
- Reset (async): all outputs 0, busy_tags=0000, all timeout counters 0, FSM=IDLE. In-flight operations are discarded. After deassertion, op_ready is valid from the first posedge.
- Issue FSM: IDLE, OP1, OP2. All req_* outputs are registered.
  - Accept at edge k, from IDLE or OP2, moves the FSM to OP1.
  - Cycle k+1 (OP1): req_cmd_out=cmd, req_tag_out=tag, req_data_out=d1.
  - Cycle k+2 (OP2): req_cmd_out=0, req_tag_out=0, req_data_out=d2.
  - OP2 with no accept moves to IDLE. IDLE drives all req_* outputs to 0.
- op_ready = (FSM==IDLE or FSM==OP2) && busy_tags != 1111. Combinational from registered state only; never depends on op_valid. Peak throughput: one operation per 2 cycles.
- Tag allocation: the lowest-numbered clear busy bit, set at the accept edge.
  - A tag freed at edge k is visible to allocation only after edge k, never reused within the same edge.
- Response capture: out_resp!=0 with busy_tags[out_tag]=1, sampled at edge k.
  - Edge k: clear the busy bit and the counter.
  - Cycle k+1: rsp_valid=1, rsp_tag=out_tag, rsp_resp=out_resp, rsp_data=out_data, rsp_timeout=0.
- Spurious response: out_resp!=0 with the busy bit clear gives an rsp_spurious pulse on cycle k+1. No rsp_valid, no state change.
- Timeout counters:
  - One counter per tag, width clog2(TIMEOUT+1). Loads 1 at the edge entering OP1 for that tag and increments each cycle while busy.
  - Saturates at TIMEOUT; a tag at TIMEOUT is expired.
  - Expired tag reporting: rsp_valid=1, rsp_timeout=1, rsp_resp=0, rsp_data=0, tag freed at the reporting edge.
- Report arbitration (one report per cycle):
  - A real response beats any timeout; pending timeouts wait, saturated.
  - Among multiple expired tags, the lowest tag is reported first.
  - A response arriving for an expired-but-unreported tag is reported as a normal response, and the timeout is cancelled.
- rsp_* outputs hold their last values when rsp_valid=0; only rsp_valid, rsp_timeout and rsp_spurious are pulses.
- An accept and a response capture in the same edge are independent, both take effect. The freed tag is not the allocated one.

Test Plan:
1. Reset, then op add d1=0x5 d2=0x3 -> OP1: cmd=1 tag=0 data=0x5; OP2: cmd=0 tag=0 data=0x3; busy_tags=0001. Feed out_resp=1 out_tag=0 out_data=0x8 -> next cycle rsp_valid=1 tag=0 resp=1 data=0x8; busy_tags=0000.
2. Four back-to-back ops, no responses -> tags 0,1,2,3 at one op per 2 cycles; op_ready=0 after the 4th accept. Response tag 2 -> op_ready=1 next cycle; 5th op issued with tag 2.
3. One op, no response, TIMEOUT=64 -> 64 cycles after OP1: rsp_valid=1 rsp_timeout=1 tag=0 resp=0 data=0; busy_tags=0000.
4. Idle, inject out_resp=1 out_tag=3 -> rsp_spurious pulse one cycle; rsp_valid stays 0; busy_tags unchanged.
5. Tag 0 expires on the same cycle as a response on tag 1 -> tag 1 response reported first; tag 0 timeout reported the following cycle.
6. Assert reset during OP2 -> req_* outputs 0 immediately (asynchronous); busy_tags=0000. After deassertion op_ready=1 and the next op uses tag 0.
